keccak_sponge_ctrl: RTL and testbench



---
 rtl/sha3_pkg.sv | 14 +
 rtl/keccak_round_cnt.sv | 40 ++++
 rtl/keccak_sponge_ctrl.sv | 85 ++++++++
 tb/tb_keccak_sponge_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared constants and control-state encoding for the SHA3-256 sponge slice.
package sha3_pkg;
  localparam int unsigned KECCAK_ROUNDS = 24;
  localparam int unsigned RATE_BITS     = 1088;
  localparam int unsigned DIGEST_BITS   = 256;
  localparam int unsigned ROUND_IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    PERMUTE  = 2'd2,
    DONE     = 2'd3
  } ctrl_state_t;
endpackage

// File: rtl/keccak_round_cnt.sv
// Round index counter: steps by UNROLL while enabled and wraps to 0 after the
// terminal value ROUNDS-UNROLL.
module keccak_round_cnt #(
  parameter int unsigned ROUNDS = 24,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned IDX_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             term
);
  localparam logic [IDX_W-1:0] STEP = IDX_W'(UNROLL);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - UNROLL);

  generate
    if (UNROLL == 0) begin : g_bad_zero
      $error("keccak_round_cnt: UNROLL must be non-zero");
    end else if ((ROUNDS % UNROLL) != 0) begin : g_bad_div
      $error("keccak_round_cnt: UNROLL must divide ROUNDS");
    end
    if (((ROUNDS - 1) >> IDX_W) != 0) begin : g_bad_width
      $error("keccak_round_cnt: IDX_W too narrow for ROUNDS");
    end
  endgenerate

  assign term = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= term ? '0 : cnt + STEP;
    end
  end
endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Multi-block sponge sequencing FSM: block handshake, absorb pulse, round
// stepping and digest hand-off. Optional blk_count port via SHA3_BLKCNT_EN.
module keccak_sponge_ctrl
  import sha3_pkg::*;
#(
  parameter int unsigned ROUNDS = KECCAK_ROUNDS,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned IDX_W  = ROUND_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic             state_clear,
  output logic             absorb_en,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic             busy,
  output logic             digest_valid,
`ifdef SHA3_BLKCNT_EN
  output logic [15:0]      blk_count,
`endif
  input  logic             digest_ack
);
  ctrl_state_t      state_q, state_d;
  logic             last_q;
  logic             accept;
  logic             rnd_term;
  logic [IDX_W-1:0] rnd_cnt;

  assign blk_ready    = (state_q == IDLE) || (state_q == WAIT_BLK);
  // blk_ready reads 1 in reset (IDLE), so the handshake is gated on reset too
  assign accept       = blk_valid & blk_ready & reset;
  assign absorb_en    = accept;
  assign state_clear  = accept & (state_q == IDLE);
  assign round_en     = (state_q == PERMUTE);
  assign round_idx    = round_en ? rnd_cnt : '0;
  assign busy         = (state_q != IDLE);
  assign digest_valid = (state_q == DONE);

  keccak_round_cnt #(
    .ROUNDS (ROUNDS),
    .UNROLL (UNROLL),
    .IDX_W  (IDX_W)
  ) u_round_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (round_en),
    .cnt   (rnd_cnt),
    .term  (rnd_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) last_q <= blk_last;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WAIT_BLK: if (accept) state_d = PERMUTE;
      PERMUTE:        if (rnd_term) state_d = last_q ? DONE : WAIT_BLK;
      DONE:           if (digest_ack) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

`ifdef SHA3_BLKCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_count <= '0;
    end else if (accept) begin
      if (state_q == IDLE)        blk_count <= 16'd1;
      else if (blk_count != '1)   blk_count <= blk_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed self-checking bench for keccak_sponge_ctrl (UNROLL=1 and UNROLL=4).
module tb_keccak_sponge_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       blk_valid = 1'b0, blk_last = 1'b0, digest_ack = 1'b0;
  logic       blk_ready, state_clear, absorb_en, round_en, busy, digest_valid;
  logic [4:0] round_idx;
  logic       blk_valid4 = 1'b0, blk_last4 = 1'b0, digest_ack4 = 1'b0;
  logic       blk_ready4, state_clear4, absorb_en4, round_en4, busy4, digest_valid4;
  logic [4:0] round_idx4;
`ifdef SHA3_BLKCNT_EN
  logic [15:0] blk_count, blk_count4;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  keccak_sponge_ctrl #(.ROUNDS(24), .UNROLL(1), .IDX_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (blk_valid),
    .blk_last     (blk_last),
    .blk_ready    (blk_ready),
    .state_clear  (state_clear),
    .absorb_en    (absorb_en),
    .round_en     (round_en),
    .round_idx    (round_idx),
    .busy         (busy),
    .digest_valid (digest_valid),
`ifdef SHA3_BLKCNT_EN
    .blk_count    (blk_count),
`endif
    .digest_ack   (digest_ack)
  );

  keccak_sponge_ctrl #(.ROUNDS(24), .UNROLL(4), .IDX_W(5)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (blk_valid4),
    .blk_last     (blk_last4),
    .blk_ready    (blk_ready4),
    .state_clear  (state_clear4),
    .absorb_en    (absorb_en4),
    .round_en     (round_en4),
    .round_idx    (round_idx4),
    .busy         (busy4),
    .digest_valid (digest_valid4),
`ifdef SHA3_BLKCNT_EN
    .blk_count    (blk_count4),
`endif
    .digest_ack   (digest_ack4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dvalid", 32'(digest_valid), 32'd0);
    check("rst_round_en", 32'(round_en), 32'd0);
    check("rst_round_idx", 32'(round_idx), 32'd0);
    check("rst_ready", 32'(blk_ready), 32'd1);
    blk_valid = 1'b1;
    #1;
    check("rst_no_absorb", 32'(absorb_en), 32'd0);
    check("rst_no_clear", 32'(state_clear), 32'd0);
    blk_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Single block, UNROLL=1; digest_ack at cycle 10 (PERMUTE) must be ignored
    next_cyc(); blk_valid = 1'b1; blk_last = 1'b1; #1;
    check("s1_absorb", 32'(absorb_en), 32'd1);
    check("s1_clear", 32'(state_clear), 32'd1);
    check("s1_c0_round_en", 32'(round_en), 32'd0);
    for (int c = 1; c <= 24; c++) begin
      next_cyc(); blk_valid = 1'b0; blk_last = 1'b0; digest_ack = (c == 10); #1;
      check("s1_round_en", 32'(round_en), 32'd1);
      check("s1_round_idx", 32'(round_idx), 32'(c - 1));
      check("s1_ready", 32'(blk_ready), 32'd0);
      check("s1_busy", 32'(busy), 32'd1);
    end
    for (int c = 25; c <= 30; c++) begin
      next_cyc(); digest_ack = (c == 30); #1;
      check("s1_dvalid", 32'(digest_valid), 32'd1);
      check("s1_done_round_en", 32'(round_en), 32'd0);
      check("s1_done_busy", 32'(busy), 32'd1);
    end
    next_cyc(); digest_ack = 1'b0; #1;
    check("s1_idle_busy", 32'(busy), 32'd0);
    check("s1_idle_dvalid", 32'(digest_valid), 32'd0);
    check("s1_idle_ready", 32'(blk_ready), 32'd1);

    // Three blocks with blk_valid held high: accepts at 0, 25, 50
    for (int c = 0; c <= 74; c++) begin
      logic acc;
      next_cyc(); blk_valid = 1'b1; blk_last = (c == 50); #1;
      acc = (c == 0) || (c == 25) || (c == 50);
      check("m3_absorb", 32'(absorb_en), 32'(acc));
      check("m3_clear", 32'(state_clear), 32'(c == 0));
      check("m3_round_en", 32'(round_en), 32'(!acc));
      if (!acc) check("m3_round_idx", 32'(round_idx), 32'((c % 25) - 1));
    end
    next_cyc(); #1;
    check("m3_dvalid75", 32'(digest_valid), 32'd1);
    check("m3_done_absorb", 32'(absorb_en), 32'd0);
    check("m3_done_ready", 32'(blk_ready), 32'd0);
    next_cyc(); digest_ack = 1'b1; #1;
    check("m3_dvalid76", 32'(digest_valid), 32'd1);
    next_cyc(); digest_ack = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; #1;
    check("m3_idle_busy", 32'(busy), 32'd0);

    // Back-pressure: second (last) block offered at cycle 5, accepted at 25
    for (int c = 0; c <= 49; c++) begin
      next_cyc(); blk_valid = (c == 0) || (c >= 5); blk_last = (c >= 5); #1;
      check("bp_no_overlap", 32'(absorb_en & round_en), 32'd0);
      if (c >= 1 && c <= 24) begin
        check("bp_ready", 32'(blk_ready), 32'd0);
        check("bp_absorb", 32'(absorb_en), 32'd0);
      end
      if (c == 25) begin
        check("bp_accept25", 32'(absorb_en), 32'd1);
        check("bp_clear25", 32'(state_clear), 32'd0);
      end
      if (c > 25) check("bp_round_idx", 32'(round_idx), 32'(c - 26));
    end
    next_cyc(); blk_valid = 1'b0; blk_last = 1'b0; digest_ack = 1'b1; #1;
    check("bp_dvalid50", 32'(digest_valid), 32'd1);
    next_cyc(); digest_ack = 1'b0; #1;
    check("bp_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in PERMUTE at round_idx=10
    next_cyc(); blk_valid = 1'b1; blk_last = 1'b1; #1;
    for (int c = 1; c <= 11; c++) begin
      next_cyc(); blk_valid = 1'b0; blk_last = 1'b0; #1;
    end
    check("ar_round_idx10", 32'(round_idx), 32'd10);
    reset = 1'b0; blk_valid = 1'b1; #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_round_en", 32'(round_en), 32'd0);
    check("ar_round_idx", 32'(round_idx), 32'd0);
    check("ar_absorb", 32'(absorb_en), 32'd0);
    check("ar_clear", 32'(state_clear), 32'd0);
    check("ar_dvalid", 32'(digest_valid), 32'd0);
    next_cyc();
    @(negedge clk);
    reset = 1'b1; blk_valid = 1'b0;
    next_cyc(); blk_valid = 1'b1; blk_last = 1'b1; #1;
    check("ar_next_clear", 32'(state_clear), 32'd1);
    for (int c = 1; c <= 24; c++) begin
      next_cyc(); blk_valid = 1'b0; blk_last = 1'b0; #1;
    end
    next_cyc(); digest_ack = 1'b1; #1;
    check("ar_dvalid", 32'(digest_valid), 32'd1);
    next_cyc(); digest_ack = 1'b0; #1;
    check("ar_idle_busy", 32'(busy), 32'd0);

    // UNROLL=4: six round cycles, digest at cycle 7
    next_cyc(); blk_valid4 = 1'b1; blk_last4 = 1'b1; #1;
    check("u4_absorb", 32'(absorb_en4), 32'd1);
    check("u4_clear", 32'(state_clear4), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      next_cyc(); blk_valid4 = 1'b0; blk_last4 = 1'b0; #1;
      check("u4_round_en", 32'(round_en4), 32'd1);
      check("u4_round_idx", 32'(round_idx4), 32'((c - 1) * 4));
    end
    next_cyc(); digest_ack4 = 1'b1; #1;
    check("u4_dvalid7", 32'(digest_valid4), 32'd1);
    check("u4_round_en7", 32'(round_en4), 32'd0);
    next_cyc(); digest_ack4 = 1'b0; #1;
    check("u4_idle_busy", 32'(busy4), 32'd0);

`ifdef SHA3_BLKCNT_EN
    // Five-block message: blk_count=5 in DONE, back to 1 on the next message
    for (int c = 0; c <= 124; c++) begin
      next_cyc(); blk_valid = 1'b1; blk_last = (c == 100); #1;
    end
    next_cyc(); blk_valid = 1'b0; blk_last = 1'b0; digest_ack = 1'b1; #1;
    check("bc_dvalid", 32'(digest_valid), 32'd1);
    check("bc_count5", 32'(blk_count), 32'd5);
    next_cyc(); digest_ack = 1'b0; blk_valid = 1'b1; blk_last = 1'b1; #1;
    check("bc_clear", 32'(state_clear), 32'd1);
    next_cyc(); blk_valid = 1'b0; blk_last = 1'b0; #1;
    check("bc_count1", 32'(blk_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
